// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU and a debug port; combinational grant, 1-cycle access, registered ack.
// Latency: a granted access completes in the grant cycle, and dbg_ack/dbg_rdata follow one cycle later.
// Backpressure: the CPU has priority; cpu_stall is raised only in the cycle debug wins through starvation.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          dbg_owner
);

    localparam logic       D_IDLE = 1'b0;
    localparam logic       D_ACK  = 1'b1;
    localparam logic [7:0] LIMIT  = 8'(STARVE_LIMIT);

    logic          r_state;
    logic [7:0]    r_starve_cnt;
    logic [DW-1:0] r_dbg_rdata;

    logic w_dbg_eligible;
    logic w_dbg_gnt;
    logic w_cpu_gnt;

    assign w_dbg_eligible = dbg_req & (r_state == D_IDLE);
    assign w_dbg_gnt      = w_dbg_eligible & (~cpu_req | (r_starve_cnt == LIMIT));
    assign w_cpu_gnt      = cpu_req & ~w_dbg_gnt;

    assign cpu_stall = cpu_req & w_dbg_gnt;
    assign cpu_rdata = mem_rdata;
    assign dbg_rdata = r_dbg_rdata;

    // Reset masks the externally visible strobes so an in-flight grant cannot write or ack.
    assign dbg_owner = w_dbg_gnt & ~reset;
    assign dbg_ack   = (r_state == D_ACK) & ~reset;
    assign mem_we    = ((w_dbg_gnt & dbg_we) | (w_cpu_gnt & cpu_we)) & ~reset;

    assign mem_addr  = w_dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_wdata = w_dbg_gnt ? dbg_wdata : cpu_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= D_IDLE;
            r_starve_cnt <= 8'd0;
            r_dbg_rdata  <= '0;
        end else begin
            if (w_dbg_gnt) begin
                r_dbg_rdata <= mem_rdata;
                r_state     <= D_ACK;
            end else if (r_state == D_ACK) begin
                r_state <= D_IDLE;
            end

            // Saturate at the limit so debug keeps winning until it is served.
            if (w_dbg_gnt || !dbg_req || (r_state == D_ACK)) begin
                r_starve_cnt <= 8'd0;
            end else if (w_dbg_eligible) begin
                r_starve_cnt <= (r_starve_cnt >= LIMIT) ? LIMIT : r_starve_cnt + 8'd1;
            end
        end
    end

endmodule
